seq_right_shifter: RTL

SEQ_RIGHT_SHIFTER -- requirements
Module: seq_right_shifter

---
 rtl/seq_right_shifter.sv | 66 ++++++
 1 files changed

// File: rtl/seq_right_shifter.sv
// Sequential 64-bit right shifter: byte steps while 8 or more remain, then single-bit steps.
// Supports logical (zero-fill) and arithmetic (sign-fill) shifts.
module seq_right_shifter (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [63:0] a,
  input  logic [5:0]  shamt,
  input  logic        arith,
  output logic        busy,
  output logic        done,
  output logic [63:0] result
);

  localparam int unsigned DataW = 64;
  localparam int unsigned ShW   = 6;
  localparam int unsigned ByteW = 8;

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state;
  logic [DataW-1:0] work;
  logic [ShW-1:0]   rem;
  logic             fill;

  // Single-process FSM; work, rem, fill and done are all registered.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      work  <= '0;
      rem   <= '0;
      fill  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            work  <= a;
            rem   <= shamt;
            fill  <= arith & a[DataW-1];
            state <= SHIFT;
          end
        end
        SHIFT: begin
          if (rem >= ShW'(ByteW)) begin
            work <= {{ByteW{fill}}, work[DataW-1:ByteW]};
            rem  <= rem - ShW'(ByteW);
          end else if (rem != '0) begin
            work <= {fill, work[DataW-1:1]};
            rem  <= rem - ShW'(1);
          end else begin
            // Final edge: work already holds the result.
            done  <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy   = (state == SHIFT);
  assign result = work;

endmodule
